// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, HI/LO and an iterative MULTU, registered into EX/MEM.
// Latency: 1 cycle for ALU ops; MULTU holds EX for XLEN/MUL_STEP+1 cycles, then passes to EX/MEM.
// Backpressure: mem_stall freezes EX/MEM (multiply keeps iterating); ex_busy stalls IF/ID/EX.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_ex_*                       instruction fields and control bits from the ID/EX register
//   forward_a/b, mem_wb_fwd_data  operand bypass selects and MEM/WB bypass value
//   flush, mem_stall              kill the instruction in EX / hold EX/MEM
//   ex_busy                       combinational front-end hold while a multiply is in flight
//   ex_mem_*                      EX/MEM pipeline register outputs
module ex_stage #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_ex_valid,
    input  logic [XLEN-1:0] id_ex_rs_data,
    input  logic [XLEN-1:0] id_ex_rt_data,
    input  logic [XLEN-1:0] id_ex_imm,
    input  logic [4:0]      id_ex_shamt,
    input  logic [3:0]      id_ex_alu_op,
    input  logic            id_ex_alu_src,
    input  logic            id_ex_regwrite,
    input  logic            id_ex_memread,
    input  logic            id_ex_memwrite,
    input  logic            id_ex_memtoreg,
    input  logic [4:0]      id_ex_wa,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] mem_wb_fwd_data,
    input  logic            flush,
    input  logic            mem_stall,
    output logic            ex_busy,
    output logic            ex_mem_valid,
    output logic            ex_mem_regwrite,
    output logic            ex_mem_memread,
    output logic            ex_mem_memwrite,
    output logic            ex_mem_memtoreg,
    output logic [XLEN-1:0] ex_mem_alu_out,
    output logic [XLEN-1:0] ex_mem_store_data,
    output logic [4:0]      ex_mem_wa
);

    localparam int N  = XLEN / MUL_STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_SLTU = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_LUI  = 4'hB;
    localparam logic [3:0] OP_MFHI = 4'hC;
    localparam logic [3:0] OP_MFLO = 4'hD;
    localparam logic [3:0] OP_MULT = 4'hE;
    localparam logic [3:0] OP_PASS = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] store_data;
        logic [4:0]      wa;
    } ex_mem_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   acc, acc_nxt;
    logic [2*XLEN-1:0]   mcand;
    logic [XLEN-1:0]     mplier;
    logic [XLEN-1:0]     hi, lo;
    logic [XLEN-1:0]     op_a, fwd_b, op_b, alu_res;
    logic                is_mul, mul_start, bubble;
    ex_mem_t             ex_mem_q;

    // Operand bypass; select 11 falls back to the ID/EX value.
    always_comb begin
        case (forward_a)
            2'b01:   op_a = ex_mem_alu_out;
            2'b10:   op_a = mem_wb_fwd_data;
            default: op_a = id_ex_rs_data;
        endcase
        case (forward_b)
            2'b01:   fwd_b = ex_mem_alu_out;
            2'b10:   fwd_b = mem_wb_fwd_data;
            default: fwd_b = id_ex_rt_data;
        endcase
        op_b = id_ex_alu_src ? id_ex_imm : fwd_b;
    end

    always_comb begin
        alu_res = '0;
        case (id_ex_alu_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_SLL:  alu_res = op_b << id_ex_shamt;
            OP_SRL:  alu_res = op_b >> id_ex_shamt;
            OP_SRA:  alu_res = $signed(op_b) >>> id_ex_shamt;
            OP_LUI:  alu_res = {id_ex_imm[15:0], 16'h0000};
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            OP_MULT: alu_res = '0;
            OP_PASS: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    assign is_mul    = id_ex_valid && (id_ex_alu_op == OP_MULT);
    assign mul_start = (state == S_IDLE) && is_mul && !flush && !mem_stall;

    // Shift-add step: multiplicand moves left, multiplier right, MUL_STEP bits per cycle.
    always_comb begin
        acc_nxt = acc;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier[j]) begin
                acc_nxt = acc_nxt + (mcand << j);
            end
        end
    end

    // A MULTU waiting in IDLE also raises ex_busy so it is not lost while mem_stall defers its start.
    always_comb begin
        state_nxt = state;
        ex_busy   = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_mul && !flush) begin
                    ex_busy = 1'b1;
                end
                if (mul_start) begin
                    state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                ex_busy = 1'b1;
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || !mem_stall) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_nxt;
            if (mul_start) begin
                mcand  <= {{XLEN{1'b0}}, op_a};
                mplier <= fwd_b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == S_MUL) begin
                acc    <= acc_nxt;
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
                cnt    <= cnt + CW'(1);
                // HI/LO take the final sum on the edge that enters DONE.
                if (!flush && cnt == CNT_LAST) begin
                    {hi, lo} <= acc_nxt;
                end
            end
        end
    end

    assign bubble = flush || !id_ex_valid || ex_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_q <= '0;
        end else if (!mem_stall) begin
            ex_mem_q.valid      <= !bubble;
            ex_mem_q.regwrite   <= !bubble && id_ex_regwrite && (id_ex_alu_op != OP_MULT);
            ex_mem_q.memread    <= !bubble && id_ex_memread;
            ex_mem_q.memwrite   <= !bubble && id_ex_memwrite;
            ex_mem_q.memtoreg   <= id_ex_memtoreg;
            ex_mem_q.alu_out    <= alu_res;
            ex_mem_q.store_data <= fwd_b;
            ex_mem_q.wa         <= id_ex_wa;
        end
    end

    assign ex_mem_valid      = ex_mem_q.valid;
    assign ex_mem_regwrite   = ex_mem_q.regwrite;
    assign ex_mem_memread    = ex_mem_q.memread;
    assign ex_mem_memwrite   = ex_mem_q.memwrite;
    assign ex_mem_memtoreg   = ex_mem_q.memtoreg;
    assign ex_mem_alu_out    = ex_mem_q.alu_out;
    assign ex_mem_store_data = ex_mem_q.store_data;
    assign ex_mem_wa         = ex_mem_q.wa;

endmodule
